// File: rtl/nios_debug_vjtag_pkg.sv
// Shared types and constants for the Nios debug virtual-JTAG driver.
// Holds the driver state enum, virtual IR codes and the default DR length.
package nios_debug_vjtag_pkg;

  localparam int SR_WIDTH_DEF = 38;
  localparam int TCK_DIV_DEF  = 4;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RTI,
    S_RSP
  } state_e;

endpackage

// File: rtl/nios_debug_vjtag_tckgen.sv
// Virtual TCK generator: TCK_DIV clk low then TCK_DIV clk high while en_i.
// Ports: clk, reset_n, en_i in; tck_o, rise_o/fall_o (one-clk, edge-ahead) out.
module nios_debug_vjtag_tckgen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [DW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          last;

  assign last = (cnt_q == DW'(TCK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en_i) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  // Strobes flag the clk whose closing edge moves tck.
  assign rise_o = en_i & ~tck_q & last;
  assign fall_o = en_i &  tck_q & last;
  assign tck_o  = tck_q;

endmodule

// File: rtl/nios_debug_vjtag_driver.sv
// Drives one UIR/CDR/SDR/UDR/RTI virtual-JTAG sequence per command.
// Ports: cmd_* in (valid/ready), rsp_* out (valid/ready), vj_* bus, busy.
module nios_debug_vjtag_driver
  import nios_debug_vjtag_pkg::*;
#(
  parameter int TCK_DIV  = TCK_DIV_DEF,
  parameter int SR_WIDTH = SR_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                vj_tck,
  output logic                vj_tdi,
  input  logic                vj_tdo,
  output logic [1:0]          vj_ir_in,
  output logic                vj_uir,
  output logic                vj_cdr,
  output logic                vj_sdr,
  output logic                vj_udr,
  output logic                vj_rti,
  output logic                busy
);

  localparam int CW = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;

  state_e              state_q, state_d;
  logic [SR_WIDTH-1:0] sr_q, sr_d;
  logic [1:0]          ir_q, ir_d;
  logic [CW-1:0]       bit_q, bit_d;
  logic                cap_q, cap_d;
  logic                tck_en;
  logic                tck_rise;
  logic                tck_fall;

  assign tck_en = (state_q != S_IDLE) && (state_q != S_RSP);

  nios_debug_vjtag_tckgen #(
    .TCK_DIV(TCK_DIV)
  ) u_tckgen (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (tck_en),
    .tck_o  (vj_tck),
    .rise_o (tck_rise),
    .fall_o (tck_fall)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    ir_d    = ir_q;
    bit_d   = bit_q;
    cap_d   = cap_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ir_d    = cmd_ir;
          sr_d    = cmd_data;
          bit_d   = '0;
          state_d = S_UIR;
        end
      end
      S_UIR: if (tck_fall) state_d = S_CDR;
      S_CDR: if (tck_fall) state_d = S_SDR;
      S_SDR: begin
        if (tck_rise) cap_d = vj_tdo;
        // Shift on the fall after the bit was captured.
        if (tck_fall) begin
          sr_d = {cap_q, sr_q[SR_WIDTH-1:1]};
          if (bit_q == CW'(SR_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = S_UDR;
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end
      end
      S_UDR: if (tck_fall) state_d = S_RTI;
      S_RTI: if (tck_fall) state_d = S_RSP;
      S_RSP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      ir_q    <= 2'b00;
      bit_q   <= '0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      ir_q    <= ir_d;
      bit_q   <= bit_d;
      cap_q   <= cap_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign vj_uir    = (state_q == S_UIR);
  assign vj_cdr    = (state_q == S_CDR);
  assign vj_sdr    = (state_q == S_SDR);
  assign vj_udr    = (state_q == S_UDR);
  assign vj_rti    = (state_q == S_RTI);
  assign vj_tdi    = vj_sdr & sr_q[0];
  assign vj_ir_in  = busy ? ir_q : 2'b00;
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_data  = rsp_valid ? sr_q : '0;

endmodule

// File: tb/tb_nios_debug_vjtag_driver.sv
// Randomized bench for nios_debug_vjtag_driver with a cycle-timing model.
// Model derives every output from elapsed clk since command accept.
module tb_nios_debug_vjtag_driver;

  localparam int W = 38;
  localparam int T = 4;
  localparam int N = (W + 4) * 2 * T;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_ir = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         vj_tck, vj_tdi, vj_tdo;
  logic [1:0]   vj_ir_in;
  logic         vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti;
  logic         busy;

  int checks = 0;
  int failures = 0;

  bit           loop = 1'b1;
  logic [W-1:0] pat = '0;

  bit           m_busy = 1'b0;
  int           m_e = 0;
  logic [1:0]   m_ir = 2'b00;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_exp = '0;
  int           sdr_r = 0, uir_r = 0, cdr_r = 0, udr_r = 0, rti_r = 0;
  logic [1:0]   ir_seen = 2'b00;
  logic         prev_tck = 1'b0;

  always #5 clk = ~clk;

  nios_debug_vjtag_driver #(
    .TCK_DIV (T),
    .SR_WIDTH(W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ir   (cmd_ir),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .vj_tck   (vj_tck),
    .vj_tdi   (vj_tdi),
    .vj_tdo   (vj_tdo),
    .vj_ir_in (vj_ir_in),
    .vj_uir   (vj_uir),
    .vj_cdr   (vj_cdr),
    .vj_sdr   (vj_sdr),
    .vj_udr   (vj_udr),
    .vj_rti   (vj_rti),
    .busy     (busy)
  );

  // Slave model: echo tdi, or play pattern bit k at the k-th SDR rise.
  assign vj_tdo = loop ? vj_tdi :
                  (sdr_r < W) ? pat[sdr_r] : 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [11:0]  act_v, exp_v;
    logic [W-1:0] exp_d;
    int           p, q;
    bit           tck, sdr, tdi;
    if (!reset_n) begin
      m_busy = 1'b0;
      m_e    = 0;
    end
    act_v = {cmd_ready, busy, rsp_valid, vj_tck, vj_tdi, vj_ir_in,
             vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti};
    exp_d = '0;
    if (!m_busy) begin
      exp_v = {1'b1, 11'b0};
    end else if (m_e <= N) begin
      p   = (m_e - 1) / (2 * T);
      q   = (m_e - 1) % (2 * T);
      tck = (q >= T);
      sdr = (p >= 2) && (p < W + 2);
      tdi = sdr ? m_data[p-2] : 1'b0;
      exp_v = {1'b0, 1'b1, 1'b0, tck, tdi, m_ir, p == 0, p == 1,
               sdr, p == W + 2, p == W + 3};
    end else begin
      exp_v = {3'b011, 2'b00, m_ir, 5'b0};
      exp_d = m_exp;
    end
    chk("cycle_ctl", 64'(act_v), 64'(exp_v));
    chk("cycle_rsp_data", 64'(rsp_data), 64'(exp_d));
    if (vj_tck && !prev_tck) begin
      if (vj_sdr) sdr_r++;
      if (vj_uir) uir_r++;
      if (vj_cdr) cdr_r++;
      if (vj_udr) udr_r++;
      if (vj_rti) rti_r++;
    end
    if (vj_uir) ir_seen = vj_ir_in;
    prev_tck = vj_tck;
    if (!reset_n) begin
      sdr_r = 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy = 1'b1;
        m_e    = 1;
        m_ir   = cmd_ir;
        m_data = cmd_data;
        m_exp  = loop ? cmd_data : pat;
        sdr_r = 0; uir_r = 0; cdr_r = 0; udr_r = 0; rti_r = 0;
      end
    end else if (m_e <= N) begin
      m_e++;
    end else if (rsp_ready) begin
      m_busy = 1'b0;
    end
  end

  task automatic run_cmd(input logic [1:0] ir, input logic [W-1:0] d,
                         input bit lp, input logic [W-1:0] pt,
                         input bit early, input int hold, input bit junk,
                         output logic [W-1:0] got, output int lat);
    logic [63:0] r;
    loop      = lp;
    pat       = pt;
    chk("accept_ready", 64'(cmd_ready), 64'd1);
    cmd_ir    = ir;
    cmd_data  = d;
    cmd_valid = 1'b1;
    rsp_ready = early;
    @(posedge clk); #1;
    lat = 1;
    cmd_valid = 1'b0;
    while (!rsp_valid && lat < 1000) begin
      if (junk) begin
        r = {$urandom, $urandom};
        cmd_valid = r[63];
        cmd_ir    = r[1:0];
        cmd_data  = r[W-1:0];
      end
      @(posedge clk); #1;
      lat++;
    end
    cmd_valid = 1'b0;
    chk("rsp_timeout", 64'(rsp_valid), 64'd1);
    got = rsp_data;
    if (!early && hold > 0) begin
      cmd_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("hold_state", {61'b0, rsp_valid, cmd_ready, busy}, 64'b101);
        chk("hold_data", 64'(rsp_data), 64'(got));
      end
      cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_after_rsp", {61'b0, cmd_ready, rsp_valid, busy}, 64'b100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] got;
    logic [63:0]  r1, r2;
    int           lat, highs;
    bit           seen;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset_ctl", {52'b0, cmd_ready, busy, rsp_valid, vj_tck, vj_tdi,
        vj_ir_in, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti},
        64'h800);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    highs = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (vj_tck) highs++;
    end
    chk("idle_tck_quiet", 64'(highs), 64'd0);

    run_cmd(2'b10, 38'h3F_0000_0001, 1'b1, '0, 1'b0, 0, 1'b0, got, lat);
    chk("loop_rsp", 64'(got), 64'h3F_0000_0001);
    chk("loop_ir_uir", 64'(ir_seen), 64'd2);
    chk("latency", 64'(lat), 64'd337);
    chk("sdr_rises", 64'(sdr_r), 64'd38);
    chk("uir_rises", 64'(uir_r), 64'd1);
    chk("cdr_rises", 64'(cdr_r), 64'd1);
    chk("udr_rises", 64'(udr_r), 64'd1);
    chk("rti_rises", 64'(rti_r), 64'd1);

    run_cmd(2'b01, 38'h12_3456_789A, 1'b0, {W{1'b1}}, 1'b1, 0, 1'b0,
            got, lat);
    chk("tdo_ones", 64'(got), 64'h3F_FFFF_FFFF);
    chk("early_ready_latency", 64'(lat), 64'd337);

    run_cmd(2'b11, 38'h2A_AAAA_5555, 1'b0, '0, 1'b0, 0, 1'b1, got, lat);
    chk("tdo_zeros", 64'(got), 64'd0);

    run_cmd(2'b00, 38'h15_0F0F_F0F0, 1'b1, '0, 1'b0, 10, 1'b1, got, lat);
    chk("hold_rsp", 64'(got), 64'h15_0F0F_F0F0);

    for (int k = 0; k < 8; k++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      run_cmd(r1[63:62], r1[W-1:0], r2[63], r2[W-1:0], r2[62],
              int'(r2[61:60]), r2[59], got, lat);
      chk("rand_rsp", 64'(got), 64'(r2[63] ? r1[W-1:0] : r2[W-1:0]));
      chk("rand_latency", 64'(lat), 64'(N + 1));
    end

    loop      = 1'b1;
    cmd_ir    = 2'b01;
    cmd_data  = 38'h0A_BCDE_F012;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (sdr_r < 21 && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("reach_sdr_bit20", 64'(vj_sdr), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_ctl", {52'b0, cmd_ready, busy, rsp_valid, vj_tck, vj_tdi,
        vj_ir_in, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti},
        64'h800);
    chk("abort_rsp_data", 64'(rsp_data), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("abort_ready", 64'(cmd_ready), 64'd1);
    seen = 1'b0;
    repeat (400) begin
      @(posedge clk); #1;
      if (rsp_valid || vj_tck) seen = 1'b1;
    end
    chk("abort_no_rsp", 64'(seen), 64'd0);

    run_cmd(2'b10, 38'h3F_0000_0001, 1'b1, '0, 1'b0, 1, 1'b0, got, lat);
    chk("post_abort_rsp", 64'(got), 64'h3F_0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
